// File: rtl/mem_write_tracer_if.sv
// ---------------------------------------------------------------------------
// mem_write_tracer_if
//   Drain port of the memory write tracer: valid/ready handshake carrying the
//   head trace record {timestamp, address, data}.
//   master : the tracer (drives valid/ts/addr/data, samples ready)
//   slave  : the consumer/monitor (samples valid/ts/addr/data, drives ready)
// ---------------------------------------------------------------------------
interface mem_write_tracer_if #(
  parameter int TS_W = 16
) ();
  logic            valid;
  logic            ready;
  logic [TS_W-1:0] ts;
  logic [7:0]      addr;
  logic [15:0]     data;

  modport master (output valid, output ts, output addr, output data, input ready);
  modport slave  (input valid, input ts, input addr, input data, output ready);
endinterface

// File: rtl/mem_write_tracer.sv
// ---------------------------------------------------------------------------
// mem_write_tracer
//   Snoops the processor RAM write bus and records every distinct write as a
//   {timestamp, addr, data} record in a first-word-fall-through FIFO, which a
//   monitor drains through a valid/ready port. Never drives the processor.
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_trace_en        capture enable
//   i_mem_rw          processor RAM write enable
//   i_mem_addr        processor RAM address (8 bits)
//   i_mem_d           processor RAM write data (16 bits)
//   i_clr_overflow    pulse: clear overflow flag and drop counter
//   o_trace           drain port (valid/ready + head record)
//   o_fifo_count      occupied entries, 0..DEPTH
//   o_overflow        sticky: a record was dropped
//   o_drop_count      dropped records, saturating at 255
// ---------------------------------------------------------------------------
module mem_write_tracer #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_trace_en,
  input  logic                   i_mem_rw,
  input  logic [7:0]             i_mem_addr,
  input  logic [15:0]            i_mem_d,
  input  logic                   i_clr_overflow,
  mem_write_tracer_if.master     o_trace,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_overflow,
  output logic [7:0]             o_drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [7:0]      addr;
    logic [15:0]     data;
  } rec_t;

  logic [TS_W-1:0]  r_ts;
  logic             r_rw_q;
  logic [7:0]       r_addr_q;
  logic [15:0]      r_d_q;
  rec_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  rec_t             r_head;
  logic             r_overflow;
  logic [7:0]       r_drop_count;

  logic             w_full;
  logic             w_pop;
  logic             w_cap;
  logic             w_push;
  logic             w_drop;
  rec_t             w_rec;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_rd_ptr_next;
  rec_t             w_head_next;

  // A write is new when it starts, or when addr/data change while it is held.
  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = r_valid & o_trace.ready;
  assign w_cap  = i_trace_en & i_mem_rw &
                  (~r_rw_q | (i_mem_addr != r_addr_q) | (i_mem_d != r_d_q));
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;
  assign w_rec  = '{ts: r_ts, addr: i_mem_addr, data: i_mem_d};

  // Next occupancy, read pointer and the record that will sit at the head.
  always_comb begin
    w_count_next  = r_count;
    w_rd_ptr_next = r_rd_ptr;
    w_head_next   = r_head;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end else begin
      w_count_next = r_count;
    end
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
    end else begin
      w_rd_ptr_next = r_rd_ptr;
    end
    // The new record becomes the head only when nothing older remains;
    // its slot is not written yet, so bypass it straight from the inputs.
    if (w_push && ((r_count == CNT_W'(0)) || ((r_count == CNT_W'(1)) && w_pop))) begin
      w_head_next = w_rec;
    end else if (w_count_next != CNT_W'(0)) begin
      w_head_next = r_mem[w_rd_ptr_next];
    end else begin
      w_head_next = r_head;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  // Timestamp, tracking registers, pointers, registered head and drop status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ts         <= '0;
      r_rw_q       <= 1'b0;
      r_addr_q     <= 8'h00;
      r_d_q        <= 16'h0000;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_head       <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'h00;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_rw_q   <= i_mem_rw;
      r_addr_q <= i_mem_addr;
      r_d_q    <= i_mem_d;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != CNT_W'(0));
      r_head   <= w_head_next;
      // A drop in the clearing cycle is still reported as the first drop.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (i_clr_overflow) begin
          r_drop_count <= 8'd1;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end else if (i_clr_overflow) begin
        r_overflow   <= 1'b0;
        r_drop_count <= 8'h00;
      end
    end
  end

  assign o_trace.valid = r_valid;
  assign o_trace.ts    = r_head.ts;
  assign o_trace.addr  = r_head.addr;
  assign o_trace.data  = r_head.data;
  assign o_fifo_count  = r_count;
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_mem_write_tracer.sv
// ---------------------------------------------------------------------------
// tb_mem_write_tracer
//   Drives directed and $urandom stimulus into mem_write_tracer and compares
//   every cycle against a queue-based reference model of the trace buffer.
// ---------------------------------------------------------------------------
module tb_mem_write_tracer;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [7:0]      addr;
    logic [15:0]     data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_en;
  logic        mem_rw;
  logic [7:0]  mem_addr;
  logic [15:0] mem_d;
  logic        clr_overflow;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  mem_write_tracer_if #(.TS_W(TS_W)) trace_if ();

  mem_write_tracer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_trace_en     (trace_en),
    .i_mem_rw       (mem_rw),
    .i_mem_addr     (mem_addr),
    .i_mem_d        (mem_d),
    .i_clr_overflow (clr_overflow),
    .o_trace        (trace_if),
    .o_fifo_count   (fifo_count),
    .o_overflow     (overflow),
    .o_drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  rec_t            mq[$];
  logic [TS_W-1:0] m_ts;
  logic            m_rw_q;
  logic [7:0]      m_addr_q;
  logic [15:0]     m_d_q;
  logic            m_ovf;
  int              m_drops;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // one clock cycle: drive, update model at the edge, compare at the negedge
  task automatic tick(input logic r, input logic te, input logic rw, input logic [7:0] a,
                      input logic [15:0] dd, input logic rdy, input logic cl);
    logic pop;
    logic cap;
    logic dropped;
    rec_t rec;
    rst = r; trace_en = te; mem_rw = rw; mem_addr = a; mem_d = dd;
    trace_if.ready = rdy; clr_overflow = cl;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ts = '0; m_rw_q = 1'b0; m_addr_q = 8'h00; m_d_q = 16'h0000;
      m_ovf = 1'b0; m_drops = 0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      cap = te && rw && (!m_rw_q || (a != m_addr_q) || (dd != m_d_q));
      rec = '{ts: m_ts, addr: a, data: dd};
      dropped = 1'b0;
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(rec);
        else dropped = 1'b1;
      end
      if (dropped) begin
        m_ovf = 1'b1;
        m_drops = cl ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (cl) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
      m_rw_q = rw; m_addr_q = a; m_d_q = dd;
      m_ts = m_ts + 1'b1;
    end
    @(negedge clk);
    check("out_valid", trace_if.valid, (mq.size() != 0));
    check("fifo_count", fifo_count, mq.size());
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drops);
    if (mq.size() != 0) begin
      check("out_ts", trace_if.ts, mq[0].ts);
      check("out_addr", trace_if.addr, mq[0].addr);
      check("out_data", trace_if.data, mq[0].data);
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [15:0] rd;
    int rdy_pct;
    rst = 1'b1; trace_en = 1'b0; mem_rw = 1'b0; mem_addr = 8'h00; mem_d = 16'h0000;
    clr_overflow = 1'b0; trace_if.ready = 1'b0;
    @(negedge clk);

    // reset two cycles: outputs cleared
    tick(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    check("rst_ts", trace_if.ts, 64'd0);
    check("rst_addr", trace_if.addr, 64'd0);
    check("rst_data", trace_if.data, 64'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

    // held write yields one record
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0);
    check("held_one_rec", fifo_count, 64'd1);
    check("held_rec_ts", trace_if.ts, 64'd10);

    // distinct single-cycle writes until overflow
    for (int i = 0; i < 20; i++)
      tick(1'b0, 1'b1, 1'b1, 8'h20 + 8'(i), 16'(i * 7 + 3), 1'b0, 1'b0);
    check("ovf_full", fifo_count, 64'd16);
    check("ovf_drops", drop_count, 64'd5);

    // full FIFO: pop and push in the same cycle
    tick(1'b0, 1'b1, 1'b1, 8'h80, 16'h1234, 1'b1, 1'b0);
    check("full_pushpop", fifo_count, 64'd16);

    // alternating addresses with write held, partial drain
    for (int i = 0; i < 12; i++)
      tick(1'b0, 1'b1, 1'b1, (i % 2) ? 8'h02 : 8'h01, 16'h0055, 1'($urandom_range(0, 1)), 1'b0);
    // refill, then clear together with a drop
    for (int i = 0; i < 20; i++)
      tick(1'b0, 1'b1, 1'b1, 8'h40 + 8'(i), 16'hA000, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 8'h99, 16'hCAFE, 1'b0, 1'b1);
    check("clr_drop_wins", drop_count, 64'd1);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    check("clr_overflow", overflow, 64'd0);

    // drain, buffer three, reset mid-drain with write held
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 8'(i + 1), 16'h0F0F, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 8'h07, 16'h7777, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 8'h07, 16'h7777, 1'b1, 1'b0);
    check("rst_mid_count", fifo_count, 64'd0);
    tick(1'b0, 1'b1, 1'b1, 8'h07, 16'h7777, 1'b0, 1'b0);
    check("post_rst_ts", trace_if.ts, 64'd0);

    // randomized traffic with varying consumer speed
    for (int seg = 0; seg < 8; seg++) begin
      rdy_pct = (seg % 4) * 30;
      for (int i = 0; i < 250; i++) begin
        ra = 8'($urandom_range(0, 3));
        rd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h00AA;
        tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
             ra, rd, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 29) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
